dff_frame_rx: RTL and testbench

Downstream consumer of the 1-bit registered serial stream produced by the D-FF stage.
- Hunts for a sync byte, then deserialises a fixed-length frame MSB-first into bytes.
- Buffers bytes in a small FIFO and presents them on a valid/ready byte interface.
- Reports lock, frame count and sticky overflow status.

---
 rtl/dff_frame_rx.sv | 119 +++++++++++
 tb/tb_dff_frame_rx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_frame_rx.sv
// Serial frame receiver: hunts for a sync byte, deserialises MSB-first
// data bytes into a small FIFO and serves them on a valid/ready port.
module dff_frame_rx #(
    parameter logic [7:0] SYNC       = 8'hD5,
    parameter int         FRAME_LEN  = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 16
) (
    input  logic             c,
    input  logic             r,
    input  logic             d,
    input  logic             en,
    output logic [7:0]       byte_data,
    output logic             byte_first,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             locked,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0] LAST_C = 8'(FRAME_LEN - 1);

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0] state;
    logic [7:0] sr;
    logic [3:0] fill;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic [6:0] byte_reg;

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic [AW:0] count;

    logic       empty;
    logic       full;
    logic       match;
    logic       push;
    logic       pop;
    logic       wr;
    logic       last_byte;
    logic [8:0] push_word;

    // Fill count keeps stale bits from the previous frame out of the match window.
    assign match = (state == HUNT) && en && (fill >= 4'd7)
                   && ({sr[6:0], d} == SYNC);
    assign push      = en && (state == COLLECT) && (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == LAST_C);
    assign push_word = {(byte_cnt == 8'd0), byte_reg, d};

    assign count = wp - rp;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign pop   = !empty && byte_ready;
    // When full, a simultaneous pop frees the slot being written.
    assign wr    = push && (!full || pop);

    assign byte_valid = !empty;
    assign {byte_first, byte_data} = empty ? 9'd0 : mem[rp[AW-1:0]];
    assign locked = (state == COLLECT);

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state     <= HUNT;
            sr        <= 8'd0;
            fill      <= 4'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 8'd0;
            byte_reg  <= 7'd0;
            frame_cnt <= '0;
        end else if (en) begin
            if (state == HUNT) begin
                sr   <= {sr[6:0], d};
                fill <= (fill == 4'd8) ? fill : fill + 4'd1;
                if (match) begin
                    state    <= COLLECT;
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 8'd0;
                end
            end else begin
                byte_reg <= {byte_reg[5:0], d};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_cnt <= byte_cnt + 8'd1;
                    if (last_byte) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= HUNT;
                        sr        <= 8'd0;
                        fill      <= 4'd0;
                        byte_cnt  <= 8'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge c) begin
        if (wr) mem[wp[AW-1:0]] <= push_word;
    end

endmodule

// File: tb/tb_dff_frame_rx.sv
// Scoreboard bench for dff_frame_rx: expected bytes queued as frames are
// driven, compared as the consumer accepts them.
module tb_dff_frame_rx;

    logic        c = 1'b0;
    logic        r = 1'b0;
    logic        d = 1'b0;
    logic        en = 1'b0;
    logic        byte_ready = 1'b0;
    logic [7:0]  byte_data;
    logic        byte_first;
    logic        byte_valid;
    logic        locked;
    logic [15:0] frame_cnt;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int lock_cycles = 0;
    logic [8:0] sb[$];
    logic [8:0] mexp;

    dff_frame_rx #(
        .SYNC(8'hD5), .FRAME_LEN(4), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .c(c), .r(r), .d(d), .en(en),
        .byte_data(byte_data), .byte_first(byte_first),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .locked(locked), .frame_cnt(frame_cnt), .overflow(overflow)
    );

    always #5 c = ~c;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    always @(negedge c) begin
        if (!r && locked) lock_cycles++;
        if (!r && byte_valid && byte_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected got=%h", {byte_first, byte_data});
            end else begin
                mexp = sb.pop_front();
                if ({byte_first, byte_data} !== mexp) begin
                    bad++;
                    $display("FAIL out_byte got=%h want=%h",
                             {byte_first, byte_data}, mexp);
                end
            end
        end
    end

    task automatic bit1(input logic b);
        d = b;
        en = 1'b1;
        @(posedge c);
        #1;
        en = 1'b0;
    endtask

    task automatic idle();
        d = 1'($urandom_range(0, 1));
        en = 1'b0;
        @(posedge c);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit chk);
        for (int i = 7; i >= 0; i--) begin
            bit1(b[i]);
            if (i == 0 && chk) begin
                total++;
                if (byte_valid !== 1'b1 || byte_data !== b) begin
                    bad++;
                    $display("FAIL latency got v=%b d=%h want v=1 d=%h",
                             byte_valid, byte_data, b);
                end
            end
            if (gap) begin
                idle();
                idle();
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int nexp, input bit gap);
        logic [7:0] fb[4];
        fb = '{b0, b1, b2, b3};
        send_byte(8'hD5, gap, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k < nexp) sb.push_back({(k == 0) ? 1'b1 : 1'b0, fb[k]});
            send_byte(fb[k], gap, byte_ready);
        end
    endtask

    task automatic do_reset();
        r = 1'b1;
        d = 1'b0;
        en = 1'b0;
        @(posedge c);
        #1;
        r = 1'b0;
        sb.delete();
        lock_cycles = 0;
    endtask

    task automatic test_reset();
        r = 1'b1;
        #1;
        total++;
        if ({byte_valid, byte_data, byte_first, locked, overflow} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {byte_valid, byte_data, byte_first, locked, overflow});
        end
        total++;
        if (frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d want=0", frame_cnt);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        byte_ready = 1'b1;
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL basic_unlock got=%b want=0", locked);
        end
        idle();
        idle();
        total++;
        if (lock_cycles != 32) begin
            bad++;
            $display("FAIL basic_lock_len got=%0d want=32", lock_cycles);
        end
        total++;
        if (frame_cnt !== 16'd1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL basic_status got cnt=%0d ov=%b want cnt=1 ov=0",
                     frame_cnt, overflow);
        end
    endtask

    task automatic test_false_sync();
        logic [7:0] pre[3];
        // no D5 at any bit alignment, including across the final sync byte
        pre = '{8'hD4, 8'hAB, 8'h00};
        do_reset();
        byte_ready = 1'b1;
        for (int k = 0; k < 3; k++) send_byte(pre[k], 1'b0, 1'b0);
        total++;
        if (locked !== 1'b0 || lock_cycles != 0) begin
            bad++;
            $display("FAIL false_lock got=%b cycles=%0d want=0", locked, lock_cycles);
        end
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 4, 1'b0);
        idle();
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL false_cnt got=%0d want=1", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        s = 8'hD5;
        do_reset();
        byte_ready = 1'b1;
        send_frame(8'h10, 8'h20, 8'h30, 8'h6A, 4, 1'b0);
        bit1(1'b1);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL b2b_early_lock got=%b want=0", locked);
        end
        for (int i = 7; i >= 1; i--) bit1(s[i]);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL b2b_lock_7 got=%b want=0", locked);
        end
        bit1(s[0]);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL b2b_lock_8 got=%b want=1", locked);
        end
        sb.push_back({1'b1, 8'hA1});
        send_byte(8'hA1, 1'b0, 1'b1);
        sb.push_back({1'b0, 8'hB2});
        send_byte(8'hB2, 1'b0, 1'b1);
        sb.push_back({1'b0, 8'hC3});
        send_byte(8'hC3, 1'b0, 1'b1);
        sb.push_back({1'b0, 8'hD4});
        send_byte(8'hD4, 1'b0, 1'b1);
        idle();
        total++;
        if (frame_cnt !== 16'd2) begin
            bad++;
            $display("FAIL b2b_cnt got=%0d want=2", frame_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        byte_ready = 1'b0;
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b0);
        total++;
        if ({byte_valid, byte_first, byte_data, overflow} !== {1'b1, 1'b1, 8'h01, 1'b0}) begin
            bad++;
            $display("FAIL ovf_head got v=%b f=%b d=%h ov=%b want 1 1 01 0",
                     byte_valid, byte_first, byte_data, overflow);
        end
        send_frame(8'h05, 8'h06, 8'h07, 8'h08, 0, 1'b0);
        total++;
        if (overflow !== 1'b1 || frame_cnt !== 16'd2) begin
            bad++;
            $display("FAIL ovf_status got ov=%b cnt=%0d want ov=1 cnt=2",
                     overflow, frame_cnt);
        end
        byte_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
        idle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL ovf_drain_timeout left=%0d want=0", sb.size());
        end
        total++;
        if (byte_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after got v=%b ov=%b want v=0 ov=1",
                     byte_valid, overflow);
        end
    endtask

    task automatic test_en_gaps();
        do_reset();
        byte_ready = 1'b1;
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b1);
        idle();
        total++;
        if (frame_cnt !== 16'd1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL gaps_status got cnt=%0d lk=%b want cnt=1 lk=0",
                     frame_cnt, locked);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        byte_ready = 1'b0;
        send_byte(8'hD5, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        total++;
        if (byte_valid !== 1'b1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got v=%b lk=%b want 1 1", byte_valid, locked);
        end
        #3;
        r = 1'b1;
        #1;
        total++;
        if ({byte_valid, byte_data, byte_first, locked, overflow} !== 12'd0
            || frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset got v=%b d=%h f=%b lk=%b ov=%b cnt=%0d want 0",
                     byte_valid, byte_data, byte_first, locked, overflow, frame_cnt);
        end
        @(posedge c);
        #1;
        r = 1'b0;
        byte_ready = 1'b1;
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        total++;
        if (byte_valid !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL mid_nosync got v=%b lk=%b want 0 0", byte_valid, locked);
        end
        send_frame(8'h31, 8'h32, 8'h33, 8'h34, 4, 1'b0);
        idle();
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL mid_cnt got=%0d want=1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_sync();
        test_back_to_back();
        test_overflow();
        test_en_gaps();
        test_reset_mid();
        idle();
        idle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
